// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding,
// memory size default, opcode constants and the request fault check.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;

  // Primary opcode field (bits 31:26) values used by the downstream decoder.
  localparam logic [5:0] OPC_LUI = 6'h0F;
  localparam logic [5:0] OPC_ORI = 6'h0D;
  localparam logic [5:0] OPC_LW  = 6'h23;

  // A request faults when it is not word aligned or its last byte lies past the memory.
  function automatic logic addr_faults(input logic [31:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - 4));
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_assembler.sv
// fetch_byte_assembler: builds a big-endian 32-bit word one byte at a time,
// byte index 0 landing in bits 31:24.
module fetch_byte_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic [1:0]  idx,
  input  logic [7:0]  byte_in,
  output logic [31:0] word
);

  logic [1:0] lane;

  assign lane = 2'd3 - idx;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples its inputs from before the edge regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (load) begin
      word[{lane, 3'b000} +: 8] <= byte_in;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: accepts a word fetch request, reads four bytes
// from a byte-wide memory and returns the assembled word (or a fault) to the CPU.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  input  logic        flush,
  output logic [9:0]  mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault
);

  state_t     state, state_nxt;
  logic [9:0] base;
  logic [1:0] idx;
  logic       accept;
  logic       req_fault;

  assign req_fault = addr_faults(req_addr, MEM_BYTES);
  assign accept    = req_ready & req_valid & ~flush;

  // Outputs are gated by reset so they are quiet while reset is held.
  assign req_ready = (state == IDLE) & ~reset;
  assign rsp_valid = (state == RESP) & ~reset;
  assign mem_addr  = ((state == FETCH) && !reset) ? base + {8'b0, idx} : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      base      <= '0;
      rsp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        idx       <= '0;
        rsp_fault <= 1'b0;
      end else if (accept) begin
        base      <= req_addr[9:0];
        idx       <= '0;
        rsp_fault <= req_fault;
      end else if (state == FETCH) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) state_nxt = req_fault ? RESP : FETCH;
        FETCH:   if (idx == 2'd3) state_nxt = RESP;
        RESP:    if (rsp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A flush or a fresh accept zeroes the word, so faults report rsp_instr = 0.
  fetch_byte_assembler u_assembler (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept | flush),
    .load    ((state == FETCH) & ~flush),
    .idx     (idx),
    .byte_in (mem_rdata),
    .word    (rsp_instr)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl: a vector table of fetch
// requests plus hand-written sequences for back-pressure, flush and reset.
module tb_instr_fetch_ctrl;
  import instr_fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        flush;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_fault;

  logic [7:0]  mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  instr_fetch_ctrl #(.MEM_BYTES(1024)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .flush     (flush),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Full transaction with immediate response acceptance. Latency is counted as
  // rising edges after the accept edge until rsp_valid is seen.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] exp_instr,
                         input logic exp_fault, input string tag);
    int   k;
    logic seen;
    @(negedge clk);
    check({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) seen = 1'b1;
      else begin
        check($sformatf("%s mem_addr%0d", tag, k), mem_addr, addr[9:0] + 10'(k));
        k++;
      end
    end
    check({tag, " rsp_seen"}, seen, 1);
    check({tag, " latency"}, k, exp_fault ? 0 : 4);
    check({tag, " rsp_instr"}, rsp_instr, exp_instr);
    check({tag, " rsp_fault"}, rsp_fault, exp_fault);
    check({tag, " mem_addr_resp"}, mem_addr, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, " rsp_valid_after"}, rsp_valid, 0);
    check({tag, " req_ready_after"}, req_ready, 1);
  endtask

  // Accept a request and wait for rsp_valid without handshaking it.
  task automatic start_and_wait(input logic [31:0] addr, input string tag);
    int   k;
    logic seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 12) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (rsp_valid) seen = 1'b1;
      else k++;
    end
    check({tag, " rsp_seen"}, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 13 + 7);
    mem[0]    = {OPC_LUI, 2'b00}; mem[1]    = 8'h08; mem[2]    = 8'h12; mem[3]    = 8'h34;
    mem[4]    = {OPC_ORI, 2'b00}; mem[5]    = 8'h08; mem[6]    = 8'h00; mem[7]    = 8'hFF;
    mem[1016] = 8'hA5;            mem[1017] = 8'h5A; mem[1018] = 8'hC3; mem[1019] = 8'h3C;
    mem[1020] = {OPC_LW, 2'b00};  mem[1021] = 8'h09; mem[1022] = 8'h00; mem[1023] = 8'h10;

    vecs[0] = '{addr: 32'd0,          instr: 32'h3C081234, fault: 1'b0};
    vecs[1] = '{addr: 32'd4,          instr: 32'h340800FF, fault: 1'b0};
    vecs[2] = '{addr: 32'd1020,       instr: 32'h8C090010, fault: 1'b0};
    vecs[3] = '{addr: 32'd1016,       instr: 32'hA55AC33C, fault: 1'b0};
    vecs[4] = '{addr: 32'h00000002,   instr: 32'h0,        fault: 1'b1};
    vecs[5] = '{addr: 32'd1024,       instr: 32'h0,        fault: 1'b1};
    vecs[6] = '{addr: 32'h80000000,   instr: 32'h0,        fault: 1'b1};
    vecs[7] = '{addr: 32'd1023,       instr: 32'h0,        fault: 1'b1};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset mem_addr", mem_addr, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", req_ready, 1);
    check("post-reset rsp_instr", rsp_instr, 0);
    check("post-reset rsp_fault", rsp_fault, 0);

    for (int v = 0; v < 8; v++)
      run_req(vecs[v].addr, vecs[v].instr, vecs[v].fault, $sformatf("vec%0d", v));

    // Response back-pressure: outputs hold while rsp_ready is low.
    start_and_wait(32'd0, "hold");
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d rsp_valid", c), rsp_valid, 1);
      check($sformatf("hold%0d rsp_instr", c), rsp_instr, 32'h3C081234);
      check($sformatf("hold%0d req_ready", c), req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold release rsp_valid", rsp_valid, 0);
    check("hold release req_ready", req_ready, 1);

    // Flush while byte index 2 is on the memory bus.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush idx2 mem_addr", mem_addr, 2);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush req_ready", req_ready, 1);
    check("flush mem_addr", mem_addr, 0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("flush quiet%0d rsp_valid", c), rsp_valid, 0);
      @(negedge clk);
    end
    run_req(32'd4, 32'h340800FF, 1'b0, "post-flush");

    // Flush together with a request in IDLE must not accept it.
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'd0;
    @(posedge clk);
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    check("flush+req req_ready", req_ready, 1);
    check("flush+req mem_addr", mem_addr, 0);

    // Reset while a response is pending.
    start_and_wait(32'd4, "rst-resp");
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst-resp rsp_valid", rsp_valid, 0);
    check("rst-resp rsp_instr", rsp_instr, 0);
    check("rst-resp rsp_fault", rsp_fault, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst-resp req_ready", req_ready, 1);
    run_req(32'd0, 32'h3C081234, 1'b0, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
